// File: rtl/spi_pkg.sv
// Definitions shared by the SPI MOSI transmit and MISO receive buffers:
// FSM state encodings and default byte/count widths.
package spi_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RECEIVE = 1'b1
   } spi_state_t;

   localparam int SPI_WIDTH = 8;
   localparam int SPI_CNT_W = 5;

endpackage

// File: rtl/miso_byte_shifter.sv
// MSB-first MISO deserialiser: shifts one bit per sample strobe and flags the
// strobe that completes a byte, presenting that byte combinationally.
module miso_byte_shifter
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH
) (
   input  logic             i_SCK,
   input  logic             i_RST_N,
   input  logic             i_CLR,
   input  logic             i_SAMPLE,
   input  logic             i_MISO,
   output logic [WIDTH-1:0] o_BYTE,
   output logic             o_BYTE_DONE
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Only WIDTH-1 bits need storing: the last bit comes straight from i_MISO.
   logic [WIDTH-2:0] shreg;
   logic [BW-1:0]    bit_cnt;

   assign o_BYTE      = {shreg, i_MISO};
   assign o_BYTE_DONE = i_SAMPLE && (bit_cnt == BW'(WIDTH - 1));

   always_ff @(posedge i_SCK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (i_CLR) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (i_SAMPLE) begin
         shreg   <= o_BYTE[WIDTH-2:0];
         bit_cnt <= o_BYTE_DONE ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nbit_miso_spi_buffer.sv
// Receive buffer: collects up to N MSB-first MISO bytes into one wide word,
// byte 0 in the low bits, and pulses o_VALID when the transaction completes.
module nbit_miso_spi_buffer
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH,
   parameter int N     = 8,
   parameter int CNT_W = SPI_CNT_W
) (
   input  logic               i_SCK,
   input  logic               i_RST_N,
   input  logic               i_START,
   input  logic [CNT_W-1:0]   i_N_receive,
   input  logic               i_ABORT,
   input  logic               i_SAMPLE,
   input  logic               i_MISO,
   output logic               o_START,
   output logic               o_BUSY,
   output logic               o_MISO_FINAL_BYTE,
   output logic [CNT_W-1:0]   o_BYTE_COUNT,
   output logic [WIDTH*N-1:0] o_DATA,
   output logic               o_VALID
);

   spi_state_t         state, state_next;
   logic [CNT_W-1:0]   n_lat, n_clamp, idx;
   logic [WIDTH*N-1:0] acc, acc_merged;
   logic [WIDTH-1:0]   rx_byte;
   logic               byte_done, start_go, last_byte, shift_clr, shift_sample;

   assign n_clamp      = (i_N_receive > CNT_W'(N)) ? CNT_W'(N) : i_N_receive;
   assign start_go     = (state == ST_IDLE) && i_START && (i_N_receive != '0) && !i_ABORT;
   assign shift_sample = (state == ST_RECEIVE) && !i_ABORT && i_SAMPLE;
   assign shift_clr    = start_go || ((state == ST_RECEIVE) && i_ABORT);
   assign last_byte    = byte_done && (idx == n_lat - 1'b1);

   miso_byte_shifter #(.WIDTH(WIDTH)) u_shifter (
      .i_SCK       (i_SCK),
      .i_RST_N     (i_RST_N),
      .i_CLR       (shift_clr),
      .i_SAMPLE    (shift_sample),
      .i_MISO      (i_MISO),
      .o_BYTE      (rx_byte),
      .o_BYTE_DONE (byte_done)
   );

   // Accumulator with the byte completing this cycle merged into slot idx.
   always_comb begin
      acc_merged = acc;
      for (int b = 0; b < N; b++) begin
         if (idx == CNT_W'(b)) acc_merged[b*WIDTH +: WIDTH] = rx_byte;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start_go) state_next = ST_RECEIVE;
         ST_RECEIVE: if (i_ABORT || last_byte) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_SCK or negedge i_RST_N) begin
      if (!i_RST_N) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Abort has priority over byte completion, so an aborted transaction never publishes.
   always_ff @(posedge i_SCK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         n_lat             <= '0;
         idx               <= '0;
         acc               <= '0;
         o_START           <= 1'b0;
         o_BUSY            <= 1'b0;
         o_MISO_FINAL_BYTE <= 1'b0;
         o_BYTE_COUNT      <= '0;
         o_DATA            <= '0;
         o_VALID           <= 1'b0;
      end else begin
         o_VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_go) begin
                  n_lat             <= n_clamp;
                  idx               <= '0;
                  acc               <= '0;
                  o_START           <= 1'b1;
                  o_BUSY            <= 1'b1;
                  o_BYTE_COUNT      <= '0;
                  o_MISO_FINAL_BYTE <= (n_clamp == CNT_W'(1));
               end
            end
            ST_RECEIVE: begin
               if (i_ABORT) begin
                  o_START           <= 1'b0;
                  o_BUSY            <= 1'b0;
                  o_MISO_FINAL_BYTE <= 1'b0;
               end else if (byte_done) begin
                  acc          <= acc_merged;
                  idx          <= idx + 1'b1;
                  o_BYTE_COUNT <= o_BYTE_COUNT + 1'b1;
                  if (last_byte) begin
                     o_DATA            <= acc_merged;
                     o_VALID           <= 1'b1;
                     o_START           <= 1'b0;
                     o_BUSY            <= 1'b0;
                     o_MISO_FINAL_BYTE <= 1'b0;
                  end else if ((idx + 1'b1) == (n_lat - 1'b1)) begin
                     o_MISO_FINAL_BYTE <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nbit_miso_spi_buffer.sv
// Randomised bench for nbit_miso_spi_buffer: a bit-level behavioural model is
// compared against the DUT every cycle, with literal checks for directed cases.
module tb_nbit_miso_spi_buffer;

   localparam int WIDTH = 8;
   localparam int N     = 8;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [CNT_W-1:0] nrec = '0;
   logic             abort = 1'b0;
   logic             sample = 1'b0;
   logic             miso = 1'b0;
   logic             oStart, oBusy, oFinal, oValid;
   logic [CNT_W-1:0] oCount;
   logic [63:0]      oData;

   int tests = 0;
   int fails = 0;

   nbit_miso_spi_buffer #(.WIDTH(WIDTH), .N(N), .CNT_W(CNT_W)) dut (
      .i_SCK             (clk),
      .i_RST_N           (rst_n),
      .i_START           (start),
      .i_N_receive       (nrec),
      .i_ABORT           (abort),
      .i_SAMPLE          (sample),
      .i_MISO            (miso),
      .o_START           (oStart),
      .o_BUSY            (oBusy),
      .o_MISO_FINAL_BYTE (oFinal),
      .o_BYTE_COUNT      (oCount),
      .o_DATA            (oData),
      .o_VALID           (oValid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit st, input int nr, input bit smp, input bit md, input bit ab);
      @(negedge clk);
      start  = st;
      nrec   = nr[CNT_W-1:0];
      sample = smp;
      miso   = md;
      abort  = ab;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic sendByte(input logic [7:0] b, input int maxGap);
      for (int i = 7; i >= 0; i--) begin
         repeat ($urandom_range(0, maxGap)) applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, 0, 1, b[i], 0);
      end
   endtask

   // Behavioural model: each sampled bit lands at its MSB-first position in byte bits/8.
   bit          mActive;
   int          mN, mBits, mCnt;
   logic [63:0] mAcc, mData;
   bit          mValid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mActive = 0; mN = 0; mBits = 0; mCnt = 0;
         mAcc = '0; mData = '0; mValid = 0;
      end else begin
         mValid = 0;
         if (!mActive) begin
            if (start && nrec != 0 && !abort) begin
               mActive = 1;
               mN      = (int'(nrec) > N) ? N : int'(nrec);
               mBits   = 0;
               mCnt    = 0;
               mAcc    = '0;
            end
         end else if (abort) begin
            mActive = 0;
         end else if (sample) begin
            mAcc[(mBits / 8) * 8 + 7 - (mBits % 8)] = miso;
            mBits++;
            if (mBits % 8 == 0) mCnt++;
            if (mBits == mN * 8) begin
               mData   = mAcc;
               mValid  = 1;
               mActive = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      checkOutput("busy",  64'(oBusy),  64'(mActive));
      checkOutput("start", 64'(oStart), 64'(mActive));
      checkOutput("final", 64'(oFinal), 64'(mActive && (mBits / 8 == mN - 1)));
      checkOutput("count", 64'(oCount), 64'(mCnt[CNT_W-1:0]));
      checkOutput("data",  oData,       mData);
      checkOutput("valid", 64'(oValid), 64'(mValid));
   end

   int          validCount = 0;
   logic [63:0] lastValidData = '0;

   always @(posedge clk) begin
      #2;
      if (oValid === 1'b1) begin
         validCount++;
         lastValidData = oData;
      end
   end

   initial begin
      #2_000_000;
      fails++;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int          vc;
      logic [7:0]  rb [8];
      logic [63:0] exp64;

      idle(3);
      checkOutput("reset_data",  oData, 64'h0);
      checkOutput("reset_busy",  64'(oBusy), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      idle(2);

      // 1: single byte A5
      vc = validCount;
      applyStimulus(1, 1, 0, 0, 0);
      sendByte(8'hA5, 0);
      idle(3);
      checkOutput("t1_byte0",  64'(lastValidData[7:0]), 64'hA5);
      checkOutput("t1_upper",  lastValidData[63:8], 64'h0);
      checkOutput("t1_count",  64'(oCount), 64'd1);
      checkOutput("t1_valids", 64'(validCount - vc), 64'd1);

      // 2: three bytes with random gaps
      applyStimulus(1, 3, 0, 0, 0);
      sendByte(8'h12, 3);
      idle(1);
      checkOutput("t2_final_b1", 64'(oFinal), 64'h0);
      sendByte(8'h34, 3);
      idle(1);
      checkOutput("t2_final_b3", 64'(oFinal), 64'h1);
      sendByte(8'h56, 3);
      idle(3);
      checkOutput("t2_data", lastValidData, 64'h563412);

      // 3: request clamped from 12 to 8 bytes, trailing strobes ignored
      vc = validCount;
      exp64 = '0;
      for (int k = 0; k < 8; k++) begin
         rb[k] = 8'($urandom);
         exp64[k*8 +: 8] = rb[k];
      end
      applyStimulus(1, 12, 0, 0, 0);
      for (int k = 0; k < 8; k++) sendByte(rb[k], 1);
      sendByte(8'hFF, 0);
      idle(3);
      checkOutput("t3_data",   lastValidData, exp64);
      checkOutput("t3_count",  64'(oCount), 64'd8);
      checkOutput("t3_valids", 64'(validCount - vc), 64'd1);

      // 4: abort after 11 bits, then C3; abort coinciding with the last bit
      vc = validCount;
      applyStimulus(1, 2, 0, 0, 0);
      sendByte(8'hEE, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 1);
      idle(2);
      checkOutput("t4_no_valid", 64'(validCount - vc), 64'd0);
      checkOutput("t4_kept",     oData, exp64);
      applyStimulus(1, 1, 0, 0, 0);
      sendByte(8'hC3, 0);
      idle(2);
      checkOutput("t4_data", 64'(lastValidData[7:0]), 64'hC3);
      vc = validCount;
      applyStimulus(1, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 1);
      idle(2);
      checkOutput("t4_abort_last", 64'(validCount - vc), 64'd0);

      // 5: asynchronous reset mid-byte
      applyStimulus(1, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0);
      idle(1);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("t5_busy",  64'(oBusy), 64'h0);
      checkOutput("t5_start", 64'(oStart), 64'h0);
      checkOutput("t5_data",  oData, 64'h0);
      idle(2);
      @(negedge clk); rst_n = 1'b1;
      applyStimulus(1, 1, 0, 0, 0);
      sendByte(8'h3C, 0);
      idle(2);
      checkOutput("t5_rerun", oData, 64'h3C);

      // 6: zero-length start, IDLE strobes, abort together with start
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 1, 0);
      idle(1);
      checkOutput("t6_busy", 64'(oBusy), 64'h0);
      checkOutput("t6_data", oData, 64'h3C);
      applyStimulus(1, 2, 0, 0, 1);
      idle(1);
      checkOutput("t6_abort_start", 64'(oBusy), 64'h0);

      // Random traffic checked only by the model
      for (int t = 0; t < 12; t++) begin
         applyStimulus(1, $urandom_range(0, 3), 0, 0, 0);
         for (int c = 0; c < 60; c++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 10),
                          $urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 40) == 0);
         end
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
